// File: rtl/core_register_scoreboard.sv
// In-order scoreboard of destination registers in flight between issue and writeback.
// Stalls issue on RAW/WAW against any pending write and retires entries oldest-first.
module core_register_scoreboard #(
  parameter int P_DEPTH   = 4,
  parameter int P_DEPTH_N = 2
) (
  input  logic                 iCLOCK,
  input  logic                 inRESET,
  input  logic                 iREFRESH,
  input  logic                 iISSUE_VALID,
  input  logic                 iISSUE_DST_VALID,
  input  logic                 iISSUE_DST_SYSREG,
  input  logic [4:0]           iISSUE_DST,
  input  logic [31:0]          iISSUE_PC,
  input  logic                 iISSUE_SRC0_VALID,
  input  logic                 iISSUE_SRC0_SYSREG,
  input  logic [4:0]           iISSUE_SRC0,
  input  logic                 iISSUE_SRC1_VALID,
  input  logic                 iISSUE_SRC1_SYSREG,
  input  logic [4:0]           iISSUE_SRC1,
  output logic                 oISSUE_STALL,
  input  logic                 iWB_VALID,
  input  logic                 iWB_SYSREG,
  input  logic [4:0]           iWB_REGISTER,
  output logic                 oEMPTY,
  output logic                 oFULL,
  output logic [P_DEPTH_N:0]   oPEND_COUNT,
  output logic [31:0]          oHEAD_PC,
  output logic                 oWB_ERROR
);

  localparam logic [P_DEPTH_N:0] FULL_COUNT = (P_DEPTH_N+1)'(P_DEPTH);

  // Control state (reset) and entry payload (not reset; qualified by valid_q)
  logic [P_DEPTH-1:0]        valid_q, valid_d;
  logic [P_DEPTH_N-1:0]      wr_ptr_q, wr_ptr_d;
  logic [P_DEPTH_N-1:0]      rd_ptr_q, rd_ptr_d;
  logic [P_DEPTH_N:0]        count_q, count_d;
  logic                      wb_err_q, wb_err_d;
  logic [P_DEPTH-1:0]        sysreg_q, sysreg_d;
  logic [P_DEPTH-1:0][4:0]   reg_q, reg_d;
  logic [P_DEPTH-1:0][31:0]  pc_q, pc_d;

  logic empty, full, hit_src0, hit_src1, hit_dst, stall, push, retire, head_mismatch;

  function automatic logic op_hit(
    input logic                    op_v,
    input logic                    op_s,
    input logic [4:0]              op_r,
    input logic [P_DEPTH-1:0]      ent_v,
    input logic [P_DEPTH-1:0]      ent_s,
    input logic [P_DEPTH-1:0][4:0] ent_r
  );
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < P_DEPTH; i++) begin
      if (op_v && ent_v[i] && (ent_s[i] == op_s) && (ent_r[i] == op_r)) hit = 1'b1;
    end
    return hit;
  endfunction

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_COUNT);

  // Entries retiring this cycle still match: no same-cycle bypass
  assign hit_src0 = op_hit(iISSUE_SRC0_VALID, iISSUE_SRC0_SYSREG, iISSUE_SRC0, valid_q, sysreg_q, reg_q);
  assign hit_src1 = op_hit(iISSUE_SRC1_VALID, iISSUE_SRC1_SYSREG, iISSUE_SRC1, valid_q, sysreg_q, reg_q);
  assign hit_dst  = op_hit(iISSUE_DST_VALID,  iISSUE_DST_SYSREG,  iISSUE_DST,  valid_q, sysreg_q, reg_q);

  assign stall  = iISSUE_VALID && (hit_src0 || hit_src1 || hit_dst || (iISSUE_DST_VALID && full));
  assign push   = iISSUE_VALID && !stall && iISSUE_DST_VALID;
  assign retire = iWB_VALID && !empty;
  assign head_mismatch = (sysreg_q[rd_ptr_q] != iWB_SYSREG) || (reg_q[rd_ptr_q] != iWB_REGISTER);

  always_comb begin
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    wb_err_d = 1'b0;
    sysreg_d = sysreg_q;
    reg_d    = reg_q;
    pc_d     = pc_q;
    if (iREFRESH) begin
      valid_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wb_err_d = iWB_VALID && (empty || head_mismatch);
      if (push) begin
        valid_d[wr_ptr_q]  = 1'b1;
        sysreg_d[wr_ptr_q] = iISSUE_DST_SYSREG;
        reg_d[wr_ptr_q]    = iISSUE_DST;
        pc_d[wr_ptr_q]     = iISSUE_PC;
        wr_ptr_d           = wr_ptr_q + 1'b1;
      end
      if (retire) begin
        valid_d[rd_ptr_q] = 1'b0;
        rd_ptr_d          = rd_ptr_q + 1'b1;
      end
      case ({push, retire})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge iCLOCK) begin
    if (!inRESET) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wb_err_q <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      wb_err_q <= wb_err_d;
    end
  end

  always_ff @(posedge iCLOCK) begin
    sysreg_q <= sysreg_d;
    reg_q    <= reg_d;
    pc_q     <= pc_d;
  end

  assign oISSUE_STALL = stall;
  assign oEMPTY       = empty;
  assign oFULL        = full;
  assign oPEND_COUNT  = count_q;
  assign oHEAD_PC     = empty ? 32'h0 : pc_q[rd_ptr_q];
  assign oWB_ERROR    = wb_err_q;

endmodule

// File: tb/tb_core_register_scoreboard.sv
// Directed bench for core_register_scoreboard with immediate-assertion checks.
module tb_core_register_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        refresh;
  logic        iss_v, dst_v, dst_s;
  logic [4:0]  dst;
  logic [31:0] pc;
  logic        s0_v, s0_s, s1_v, s1_s;
  logic [4:0]  s0, s1;
  logic        stall;
  logic        wb_v, wb_s;
  logic [4:0]  wb_r;
  logic        empty, full, wb_err;
  logic [2:0]  cnt;
  logic [31:0] head_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  core_register_scoreboard #(.P_DEPTH(4), .P_DEPTH_N(2)) dut (
    .iCLOCK(clk), .inRESET(rst_n), .iREFRESH(refresh),
    .iISSUE_VALID(iss_v), .iISSUE_DST_VALID(dst_v), .iISSUE_DST_SYSREG(dst_s),
    .iISSUE_DST(dst), .iISSUE_PC(pc),
    .iISSUE_SRC0_VALID(s0_v), .iISSUE_SRC0_SYSREG(s0_s), .iISSUE_SRC0(s0),
    .iISSUE_SRC1_VALID(s1_v), .iISSUE_SRC1_SYSREG(s1_s), .iISSUE_SRC1(s1),
    .oISSUE_STALL(stall),
    .iWB_VALID(wb_v), .iWB_SYSREG(wb_s), .iWB_REGISTER(wb_r),
    .oEMPTY(empty), .oFULL(full), .oPEND_COUNT(cnt), .oHEAD_PC(head_pc),
    .oWB_ERROR(wb_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    iss_v = 0; dst_v = 0; dst_s = 0; dst = 0; pc = 0;
    s0_v = 0; s0_s = 0; s0 = 0; s1_v = 0; s1_s = 0; s1 = 0;
    wb_v = 0; wb_s = 0; wb_r = 0; refresh = 0;
  endtask

  task automatic issue_dst(input logic sys, input logic [4:0] r, input logic [31:0] p);
    idle_inputs();
    iss_v = 1; dst_v = 1; dst_s = sys; dst = r; pc = p;
  endtask

  task automatic issue_src0(input logic sys, input logic [4:0] r);
    idle_inputs();
    iss_v = 1; s0_v = 1; s0_s = sys; s0 = r;
  endtask

  task automatic push(input logic [4:0] r, input logic [31:0] p);
    issue_dst(1'b0, r, p);
    tick();
    idle_inputs();
  endtask

  task automatic wb(input logic sys, input logic [4:0] r);
    idle_inputs();
    wb_v = 1; wb_s = sys; wb_r = r;
    tick();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    tick(); tick();
    rst_n = 1;

    // Reset state
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_count", 32'(cnt), 0);
    chk("rst_head_pc", head_pc, 0);
    chk("rst_wb_err", 32'(wb_err), 0);
    issue_dst(1'b0, 5'd3, 32'h0); s0_v = 1; s0 = 5'd3; #1;
    chk("rst_no_stall", 32'(stall), 0);
    idle_inputs();

    // RAW on r3, retire with no same-cycle bypass
    push(5'd3, 32'h100);
    chk("raw_count", 32'(cnt), 1);
    chk("raw_head_pc", head_pc, 32'h100);
    issue_src0(1'b0, 5'd3); #1;
    chk("raw_stall", 32'(stall), 1);
    wb_v = 1; wb_r = 5'd3; #1;
    chk("raw_stall_wb_cycle", 32'(stall), 1);
    tick();
    wb_v = 0; #1;
    chk("raw_stall_after", 32'(stall), 0);
    chk("raw_count_after", 32'(cnt), 0);
    chk("raw_wb_err", 32'(wb_err), 0);
    tick();
    idle_inputs();
    chk("pass_through_count", 32'(cnt), 0);

    // Sysreg vs general register separation
    issue_dst(1'b1, 5'd3, 32'h200);
    tick();
    idle_inputs();
    issue_src0(1'b0, 5'd3); #1;
    chk("sys_vs_gpr_no_stall", 32'(stall), 0);
    issue_dst(1'b1, 5'd3, 32'h204); #1;
    chk("sys_waw_stall", 32'(stall), 1);
    wb(1'b1, 5'd3);
    chk("sys_wb_err", 32'(wb_err), 0);
    chk("sys_count", 32'(cnt), 0);

    // Fill with wrapping pointers (entries start at slot 2)
    push(5'd1, 32'h10);
    push(5'd2, 32'h14);
    push(5'd4, 32'h18);
    push(5'd5, 32'h1c);
    chk("full_flag", 32'(full), 1);
    chk("full_count", 32'(cnt), 4);
    chk("full_head_pc", head_pc, 32'h10);
    idle_inputs(); iss_v = 1; s0_v = 1; s0 = 5'd8; s1_v = 1; s1 = 5'd9; #1;
    chk("full_nodst_accept", 32'(stall), 0);
    tick();
    chk("full_nodst_count", 32'(cnt), 4);
    issue_dst(1'b0, 5'd6, 32'h20); #1;
    chk("full_dst_stall", 32'(stall), 1);
    wb_v = 1; wb_r = 5'd1; #1;
    chk("full_retire_stall", 32'(stall), 1);
    tick();
    wb_v = 0; #1;
    chk("after_retire_count", 32'(cnt), 3);
    chk("after_retire_head", head_pc, 32'h14);
    chk("r6_now_accept", 32'(stall), 0);
    tick();
    idle_inputs();
    chk("r6_pushed_count", 32'(cnt), 4);
    chk("r6_pushed_full", 32'(full), 1);

    // Mismatched writeback still retires, one-cycle error pulse
    wb(1'b0, 5'd9);
    chk("mis_wb_err", 32'(wb_err), 1);
    chk("mis_count", 32'(cnt), 3);
    chk("mis_head", head_pc, 32'h18);
    tick();
    chk("mis_err_clear", 32'(wb_err), 0);
    wb(1'b0, 5'd4);
    chk("wrap_head_r5", head_pc, 32'h1c);
    wb(1'b0, 5'd5);
    chk("wrap_head_r6", head_pc, 32'h20);
    wb(1'b0, 5'd6);
    chk("wrap_empty", 32'(empty), 1);
    chk("wrap_head_zero", head_pc, 0);
    chk("wrap_err", 32'(wb_err), 0);
    wb(1'b0, 5'd1);
    chk("empty_wb_err", 32'(wb_err), 1);
    chk("empty_wb_count", 32'(cnt), 0);
    tick();
    chk("empty_err_clear", 32'(wb_err), 0);

    // Refresh discards entries and same-cycle issue/writeback
    push(5'd1, 32'h30);
    push(5'd2, 32'h34);
    push(5'd3, 32'h38);
    chk("pre_refresh_count", 32'(cnt), 3);
    issue_dst(1'b0, 5'd7, 32'h3c); wb_v = 1; wb_r = 5'd9; refresh = 1;
    tick();
    idle_inputs(); #1;
    chk("refresh_empty", 32'(empty), 1);
    chk("refresh_count", 32'(cnt), 0);
    chk("refresh_head", head_pc, 0);
    chk("refresh_wb_err", 32'(wb_err), 0);
    issue_src0(1'b0, 5'd7); #1;
    chk("refresh_r7_absent", 32'(stall), 0);
    idle_inputs();

    // Reset mid-operation behaves the same
    push(5'd1, 32'h40);
    push(5'd2, 32'h44);
    push(5'd3, 32'h48);
    issue_dst(1'b0, 5'd7, 32'h4c); wb_v = 1; wb_r = 5'd9; rst_n = 0;
    tick();
    rst_n = 1;
    idle_inputs(); #1;
    chk("reset_empty", 32'(empty), 1);
    chk("reset_count", 32'(cnt), 0);
    chk("reset_head", head_pc, 0);
    chk("reset_wb_err", 32'(wb_err), 0);
    issue_src0(1'b0, 5'd7); #1;
    chk("reset_r7_absent", 32'(stall), 0);
    idle_inputs();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_register_scoreboard.md
# core_register_scoreboard

Dispatch-side counterpart of the single-entry register hazard controller: a multi-entry, in-order scoreboard of destination registers still in flight between issue and writeback. The issue stage presents each instruction's source and destination operands; the block stalls on RAW/WAW conflicts with any pending write and records accepted destinations. The writeback stage retires entries strictly oldest-first. It sits between decode/dispatch and the writeback stage, and replaces single-register tracking when more than one writer may be outstanding.

## Interface
- P_DEPTH, 4, number of pending-write entries; must be a power of two.
- P_DEPTH_N, 2, log2(P_DEPTH); pointer width.

- iCLOCK  in  1  core clock; all state updates on its rising edge.
- inRESET  in  1  reset, synchronous and active-low; sampled on the iCLOCK rising edge.
- iREFRESH  in  1  pipeline flush; discards all entries on the next edge.
- iISSUE_VALID  in  1  instruction presented at issue.
- iISSUE_DST_VALID / iISSUE_DST_SYSREG / iISSUE_DST  in  1/1/5  destination write flag, register file select (1 = system register), register index.
- iISSUE_PC  in  32  PC of the issuing instruction; stored with the entry.
- iISSUE_SRC0_VALID / iISSUE_SRC0_SYSREG / iISSUE_SRC0  in  1/1/5  source operand 0.
- iISSUE_SRC1_VALID / iISSUE_SRC1_SYSREG / iISSUE_SRC1  in  1/1/5  source operand 1.
- oISSUE_STALL  out  1  combinational; the presented instruction must be held.
- iWB_VALID / iWB_SYSREG / iWB_REGISTER  in  1/1/5  writeback of the oldest pending write.
- oEMPTY  out  1  no pending entries.
- oFULL  out  1  P_DEPTH entries pending.
- oPEND_COUNT  out  P_DEPTH_N+1  number of pending entries.
- oHEAD_PC  out  32  PC of the oldest entry; 0 when empty.
- oWB_ERROR  out  1  registered one-cycle pulse on an illegal writeback.

## Operation
- Storage: P_DEPTH entries {valid, sysreg, reg[4:0], pc[31:0]} in a circular buffer. Write pointer, read pointer, and count are each P_DEPTH_N bits, except count, which is P_DEPTH_N+1 bits. Pointers wrap modulo P_DEPTH.
- An operand matches an entry when the entry is valid, the operand's valid flag is set, its sysreg equals the entry's sysreg, and its reg equals the entry's reg. A general register and a system register with the same index never match.
- oISSUE_STALL = iISSUE_VALID && (SRC0 matches any entry || SRC1 matches any entry || DST matches any entry || (iISSUE_DST_VALID && oFULL)).
- Conservative rule: an entry retiring in the same cycle still causes a match; there is no same-cycle bypass.
- Accept: iISSUE_VALID && !oISSUE_STALL.
  - Accepted with iISSUE_DST_VALID = 1: write {1, DST_SYSREG, DST, PC} at the write pointer, increment the write pointer.
  - Accepted with no destination: passes through; no state change.
- Retire: iWB_VALID && !oEMPTY.
  - Clear the head entry's valid bit, increment the read pointer.
  - If {iWB_SYSREG, iWB_REGISTER} differs from the head entry: still retire, and pulse oWB_ERROR.
- iWB_VALID while oEMPTY: no state change; pulse oWB_ERROR.
- Simultaneous push and retire: both happen; count is unchanged.
  - At full, a push is already blocked by stall, even if a retire occurs in the same cycle.
- iREFRESH: on the next edge, clear all valid bits, pointers, and count, and clear oWB_ERROR. Issue and writeback in that same cycle are ignored.
- Reset (inRESET = 0 at an edge): same as iREFRESH. Resulting output values: oEMPTY = 1, oFULL = 0, oPEND_COUNT = 0, oHEAD_PC = 0, oWB_ERROR = 0, oISSUE_STALL = 0 (no valid entries). Reset takes priority over iREFRESH and is honoured mid-operation with no drain.

## Timing
- oISSUE_STALL: combinational from the issue inputs and registered state; no input-to-state latency.
- A pushed entry is visible to match logic, oPEND_COUNT, and oFULL from the cycle after the push edge.
- Retirement takes effect on the edge where iWB_VALID is sampled. A dependent instruction waiting on that register issues no earlier than the following cycle.
- Minimum back-to-back dependent issue: a write followed by a read of the same register has at least one stall cycle per pending cycle until writeback, plus zero cycles after the retire edge.
- oWB_ERROR is registered: it asserts in the cycle after the offending iWB_VALID and lasts one cycle unless repeated.
- Throughput: one push and one retire per cycle.

## Test plan
- Reset then idle → oEMPTY = 1, oPEND_COUNT = 0, oHEAD_PC = 0, oISSUE_STALL = 0 with iISSUE_VALID = 1 and any operands.
- Issue DST = r3 (PC 0x100), next cycle issue SRC0 = r3 → oISSUE_STALL = 1. Assert WB r3 → stall stays 1 during the WB cycle; in the next cycle stall = 0 and oPEND_COUNT = 0.
- Pending sysreg 3; issue SRC0 = general r3 → no stall. Issue DST = sysreg 3 → stall (WAW).
- Push r1, r2, r4, r5 (oFULL = 1, oPEND_COUNT = 4). A no-dst instruction with unrelated sources is accepted; DST = r6 stalls. Retire r1 with simultaneous DST = r6 → still stalls that cycle, accepted next cycle. Pointer wrap is then verified by retiring r2, r4, r5, r6 in order, with oHEAD_PC tracking each entry.
- WB of r9 while head is r2 → r2 retired, oWB_ERROR = 1 for exactly one cycle. WB while empty → oWB_ERROR pulse, count stays 0.
- Three entries pending, assert iREFRESH together with an issue of DST = r7 and a WB → next cycle oEMPTY = 1 and r7 is not recorded. Repeat with inRESET = 0 → same result, oWB_ERROR = 0.
